// File: rtl/iddr_resp.sv
// iddr word-access responder: a one-entry line buffer answers repeated reads of
// the same word; misses and writes go to a req/ack backing memory port.
module iddr_resp #(
    parameter int WORD_WIDTH     = 32,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] iddr_addr,
    input  logic                  iddr_read,
    input  logic                  iddr_write,
    input  logic [WORD_WIDTH-1:0] iddr_wdata,
    output logic [WORD_WIDTH-1:0] iddr_rdata,
    output logic                  iddr_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WORD_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2,
        S_WR_DONE = 2'd3
    } state_t;

    // Byte-offset bits within a word are dropped from every compare and from
    // the address sent to the backing port.
    localparam logic [WORD_WIDTH-1:0] WORD_MASK = ~(WORD_WIDTH'(BYTES_PER_WORD - 1));

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_buf_valid;
    logic [WORD_WIDTH-1:0] r_buf_addr;
    logic [WORD_WIDTH-1:0] r_buf_data;
    logic [WORD_WIDTH-1:0] r_wr_addr;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [WORD_WIDTH-1:0] r_mem_addr;
    logic [WORD_WIDTH-1:0] r_mem_wdata;

    logic [WORD_WIDTH-1:0] w_word;
    logic                  w_hit;
    logic                  w_same_wr;
    logic                  w_stall;
    logic                  w_issue_rd;
    logic                  w_issue_wr;
    logic                  w_rd_done;
    logic                  w_wr_done;
    logic                  w_wr_through;

    assign w_word    = iddr_addr & WORD_MASK;
    assign w_hit     = iddr_read & ~iddr_write & r_buf_valid & (w_word == r_buf_addr);
    assign w_same_wr = iddr_write & (w_word == r_wr_addr);

    // Acks are only meaningful while an access is outstanding.
    assign w_rd_done    = (r_state == S_RD_WAIT) & mem_ack;
    assign w_wr_done    = (r_state == S_WR_WAIT) & mem_ack;
    assign w_wr_through = w_wr_done & r_buf_valid & (r_buf_addr == r_wr_addr);

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_issue_rd   = 1'b0;
        w_issue_wr   = 1'b0;
        case (r_state)
            S_IDLE, S_WR_DONE: begin
                if ((r_state == S_WR_DONE) && w_same_wr) begin
                    // The held write already completed; do not reissue it.
                    w_state_next = S_WR_DONE;
                end else if (iddr_write) begin
                    w_stall      = 1'b1;
                    w_issue_wr   = 1'b1;
                    w_state_next = S_WR_WAIT;
                end else if (iddr_read && !w_hit) begin
                    w_stall      = 1'b1;
                    w_issue_rd   = 1'b1;
                    w_state_next = S_RD_WAIT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                w_stall = 1'b1;
                if (mem_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WR_WAIT: begin
                w_stall = 1'b1;
                if (mem_ack) begin
                    w_state_next = S_WR_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wr_addr   <= '0;
        end else begin
            if (w_issue_wr) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= w_word;
                r_mem_wdata <= iddr_wdata;
                r_wr_addr   <= w_word;
            end else if (w_issue_rd) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= w_word;
            end else if (w_rd_done || w_wr_done) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
        end else begin
            if (w_rd_done) begin
                r_buf_valid <= 1'b1;
                r_buf_addr  <= r_mem_addr;
                r_buf_data  <= mem_rdata;
            end else if (w_wr_through) begin
                r_buf_data <= r_mem_wdata;
            end
        end
    end

    assign iddr_rdata = r_buf_data;
    assign iddr_stall = w_stall;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_iddr_resp.sv
// Directed bench for iddr_resp: a vector table of word accesses against a
// latency-programmable backing memory model, plus hand-written corner sequences.
module tb_iddr_resp;

    logic        clk;
    logic        rst_n;
    logic [31:0] iddr_addr;
    logic        iddr_read;
    logic        iddr_write;
    logic [31:0] iddr_wdata;
    logic [31:0] iddr_rdata;
    logic        iddr_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        model_ack;
    logic [31:0] model_rdata;
    logic        force_ack;
    logic        model_en;
    int          cur_lat;
    int          req_cnt;
    logic        last_we;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    logic [31:0] store [0:1023];

    int tests;
    int fails;

    assign mem_ack   = model_ack | force_ack;
    assign mem_rdata = force_ack ? 32'hFFFF_FFFF : model_rdata;

    iddr_resp #(
        .WORD_WIDTH    (32),
        .BYTES_PER_WORD(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iddr_addr  (iddr_addr),
        .iddr_read  (iddr_read),
        .iddr_write (iddr_write),
        .iddr_wdata (iddr_wdata),
        .iddr_rdata (iddr_rdata),
        .iddr_stall (iddr_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory: acks in the cur_lat-th cycle of a mem_req pulse; also
    // records every new request for the checks.
    initial begin
        logic prev_req;
        int   lat_cnt;
        prev_req    = 1'b0;
        lat_cnt     = 0;
        model_ack   = 1'b0;
        model_rdata = '0;
        req_cnt     = 0;
        last_we     = 1'b0;
        last_addr   = '0;
        last_wdata  = '0;
        for (int i = 0; i < 1024; i++) store[i] = 32'h0;
        store[32'h100 >> 2] = 32'hDEAD_BEEF;
        store[32'h104 >> 2] = 32'hCAFE_0104;
        store[32'h204 >> 2] = 32'hA5A5_0204;
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                req_cnt++;
                last_we    = mem_we;
                last_addr  = mem_addr;
                last_wdata = mem_wdata;
                lat_cnt    = 0;
            end
            prev_req  = mem_req;
            model_ack = 1'b0;
            if (mem_req && model_en) begin
                lat_cnt++;
                if (lat_cnt == cur_lat) begin
                    model_ack = 1'b1;
                    if (mem_we) store[mem_addr[11:2]] = mem_wdata;
                    else        model_rdata = store[mem_addr[11:2]];
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives a request just after a posedge and waits for stall to drop.
    task automatic access(input logic we, input logic re, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat,
                          output int stall_n, output logic [31:0] rdata,
                          output int reqs);
        int start_reqs;
        bit done;
        start_reqs = req_cnt;
        cur_lat    = lat;
        iddr_write = we;
        iddr_read  = re;
        iddr_addr  = addr;
        iddr_wdata = wdata;
        stall_n    = 0;
        done       = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!iddr_stall) begin
                done = 1;
                break;
            end
            stall_n++;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL access_timeout: stall still 1 after %0d cycles, expected release", stall_n);
        end
        rdata = iddr_rdata;
        @(posedge clk);
        #1;
        reqs = req_cnt - start_reqs;
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          exp_stall;
        logic [31:0] exp_rdata;
        int          exp_reqs;
        logic        exp_we;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          stall_n;
        int          reqs;
        logic [31:0] rdata;
        bit          seen;

        tests = 0;
        fails = 0;

        vecs[0] = '{"rd_miss_100",  1'b0, 1'b1, 32'h100, 32'h0,         3, 4, 32'hDEAD_BEEF, 1, 1'b0, 32'h100};
        vecs[1] = '{"rd_hit_100",   1'b0, 1'b1, 32'h100, 32'h0,         1, 0, 32'hDEAD_BEEF, 0, 1'b0, 32'h0};
        vecs[2] = '{"rd_hit_102",   1'b0, 1'b1, 32'h102, 32'h0,         1, 0, 32'hDEAD_BEEF, 0, 1'b0, 32'h0};
        vecs[3] = '{"wr_100",       1'b1, 1'b0, 32'h100, 32'h1234_5678, 1, 2, 32'h1234_5678, 1, 1'b1, 32'h100};
        vecs[4] = '{"rd_hit_wt",    1'b0, 1'b1, 32'h100, 32'h0,         1, 0, 32'h1234_5678, 0, 1'b0, 32'h0};
        vecs[5] = '{"rd_miss_204",  1'b0, 1'b1, 32'h204, 32'h0,         2, 3, 32'hA5A5_0204, 1, 1'b0, 32'h204};
        vecs[6] = '{"rd_miss_107",  1'b0, 1'b1, 32'h107, 32'h0,         1, 2, 32'hCAFE_0104, 1, 1'b0, 32'h104};
        vecs[7] = '{"rdwr_300",     1'b1, 1'b1, 32'h300, 32'h0BAD_F00D, 2, 3, 32'hCAFE_0104, 1, 1'b1, 32'h300};

        rst_n      = 1'b0;
        iddr_addr  = '0;
        iddr_read  = 1'b0;
        iddr_write = 1'b0;
        iddr_wdata = '0;
        force_ack  = 1'b0;
        model_en   = 1'b1;
        cur_lat    = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_rdata", iddr_rdata, 32'h0);
        check("reset_stall", {31'b0, iddr_stall}, 32'h0);
        check("reset_req",   {31'b0, mem_req}, 32'h0);
        check("reset_we",    {31'b0, mem_we}, 32'h0);
        check("reset_addr",  mem_addr, 32'h0);
        check("reset_wdata", mem_wdata, 32'h0);
        $display("[TB] reset: rdata=0x%08h stall=%0b req=%0b", iddr_rdata, iddr_stall, mem_req);
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            access(vecs[v].we, vecs[v].re, vecs[v].addr, vecs[v].wdata, vecs[v].lat,
                   stall_n, rdata, reqs);
            check({vecs[v].name, "_stall"}, stall_n, vecs[v].exp_stall);
            check({vecs[v].name, "_rdata"}, rdata, vecs[v].exp_rdata);
            check({vecs[v].name, "_reqs"}, reqs, vecs[v].exp_reqs);
            if (vecs[v].exp_reqs == 1) begin
                check({vecs[v].name, "_we"}, {31'b0, last_we}, {31'b0, vecs[v].exp_we});
                check({vecs[v].name, "_addr"}, last_addr, vecs[v].exp_addr);
                if (vecs[v].exp_we) check({vecs[v].name, "_wdata"}, last_wdata, vecs[v].wdata);
            end
            $display("[TB] %s: stall=%0d rdata=0x%08h reqs=%0d", vecs[v].name, stall_n, rdata, reqs);
        end

        // Held write after completion must not be reissued.
        access(1'b1, 1'b0, 32'h200, 32'h5555_AAAA, 1, stall_n, rdata, reqs);
        check("hold_wr_stall", stall_n, 2);
        check("hold_wr_addr", last_addr, 32'h200);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_wr_nostall", {31'b0, iddr_stall}, 32'h0);
            check("hold_wr_noreq", {31'b0, mem_req}, 32'h0);
            @(posedge clk);
            #1;
        end
        reqs = req_cnt;
        iddr_write = 1'b0;
        @(posedge clk);
        #1;
        check("hold_wr_total_reqs", req_cnt, reqs);
        $display("[TB] hold_wr: req_cnt=%0d", req_cnt);

        // Reset in the middle of a read miss, then a stray late ack.
        model_en  = 1'b0;
        iddr_read = 1'b1;
        iddr_addr = 32'h100;
        seen      = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1;
                break;
            end
        end
        check("rst_mid_req_seen", {31'b0, seen}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_req_drop", {31'b0, mem_req}, 32'h0);
        check("rst_mid_rdata", iddr_rdata, 32'h0);
        @(posedge clk);
        #1;
        iddr_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        force_ack = 1'b1;
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        @(negedge clk);
        check("late_ack_req", {31'b0, mem_req}, 32'h0);
        check("late_ack_rdata", iddr_rdata, 32'h0);
        check("late_ack_stall", {31'b0, iddr_stall}, 32'h0);
        @(posedge clk);
        #1;
        model_en = 1'b1;
        access(1'b0, 1'b1, 32'h100, 32'h0, 1, stall_n, rdata, reqs);
        check("post_rst_stall", stall_n, 2);
        check("post_rst_reqs", reqs, 1);
        check("post_rst_rdata", rdata, 32'h1234_5678);
        $display("[TB] post_rst_read: stall=%0d rdata=0x%08h reqs=%0d", stall_n, rdata, reqs);
        iddr_read = 1'b0;
        @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iddr_resp.md
# iddr_resp

Responder end of the iddr word-access interface. Fetch and memory stages drive it as initiators, with a combinational request each cycle and read data registered by the initiator at the next edge when not stalled. The block answers repeated reads of the same word from a one-entry line buffer with zero added latency. It forwards misses and writes to a backing memory port with a req/ack handshake, and raises `iddr_stall` while an access is outstanding.

## Interface
- `WORD_WIDTH`, 32, data width; `iddr_addr` and `mem_addr` are also `WORD_WIDTH` wide.
- `BYTES_PER_WORD`, 4, address stride; the low log2(`BYTES_PER_WORD`) address bits are ignored in all compares and forwarded as zero.
- `clk`  in  1  clock, all state on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `iddr_addr`  in  `WORD_WIDTH`  byte address of the request.
- `iddr_read`  in  1  read request.
- `iddr_write`  in  1  write request; has priority over `iddr_read`.
- `iddr_wdata`  in  `WORD_WIDTH`  write data.
- `iddr_rdata`  out  `WORD_WIDTH`  read data; combinational from the buffer.
- `iddr_stall`  out  1  access not complete; the initiator must hold its request.
- `mem_req`  out  1  backing request, registered.
- `mem_we`  out  1  backing write enable, registered.
- `mem_addr`  out  `WORD_WIDTH`  backing word address, registered, low bits zero.
- `mem_wdata`  out  `WORD_WIDTH`  backing write data, registered.
- `mem_ack`  in  1  backing completion, a single-cycle pulse.
- `mem_rdata`  in  `WORD_WIDTH`  backing read data, valid with `mem_ack`.

## Operation
- **State:** FSM {IDLE, RD_WAIT, WR_WAIT, WR_DONE}; line buffer {`buf_valid`, `buf_addr`, `buf_data`}; `wr_addr` register.
- **Hit:** `iddr_read` & ~`iddr_write` & `buf_valid` & word(`iddr_addr`)==`buf_addr`. `iddr_rdata`=`buf_data` at all times.
- **IDLE:**
  - write: `iddr_stall`=1; latch `mem_addr`, `mem_wdata`, `wr_addr`; `mem_req`<=1, `mem_we`<=1; go to WR_WAIT.
  - read miss: `iddr_stall`=1; latch `mem_addr`; `mem_req`<=1, `mem_we`<=0; go to RD_WAIT.
  - read hit or no request: `iddr_stall`=0; stay.
- **RD_WAIT:** `iddr_stall`=1; `mem_*` held stable. On `mem_ack`: `buf_data`<=`mem_rdata`, `buf_addr`<=`mem_addr`, `buf_valid`<=1, `mem_req`<=0, go to IDLE.
- **WR_WAIT:** `iddr_stall`=1. On `mem_ack`: `mem_req`<=0, `mem_we`<=0, go to WR_DONE. If `buf_valid` and `buf_addr`==`wr_addr`, `buf_data`<=`mem_wdata` (write-through).
- **WR_DONE:** `iddr_stall`=0.
  - While `iddr_write` and word(`iddr_addr`)==`wr_addr`: stay. The write counts as already done and is not reissued.
  - Otherwise evaluate the current request exactly as in IDLE; a new write or miss goes directly to WR_WAIT or RD_WAIT.
- **Ack timing:** `mem_ack` outside RD_WAIT/WR_WAIT is ignored.
- **Input changes:** changes on `iddr_*` during RD_WAIT/WR_WAIT are ignored; the latched access completes.

## Timing
- **Reset values:** state=IDLE, `buf_valid`=0, `buf_addr`=0, `buf_data`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. Hence `iddr_rdata`=0, and `iddr_stall`=0 unless a request is present.
- **Hit:** 0 added cycles; `iddr_stall` stays low.
- **Read miss:** cycle 0 miss detected, stall=1; `mem_req` high from cycle 1 until the edge sampling `mem_ack` (cycle k). Cycle k+1: buffer valid, hit, stall=0. Minimum stall is 2 cycles with ack at cycle 1.
- **Write:** same request timing; stall=0 from cycle k+1.
- **Reset mid-access:** `mem_req` drops immediately; the backing port must tolerate an abandoned request. Any late ack arrives in IDLE and is ignored.
- `mem_req` never re-asserts in the cycle after an ack.

## Test plan
- Reset, then read 0x100 with `mem_ack` 3 cycles after `mem_req` and `mem_rdata`=0xDEADBEEF. Required: stall high 4 cycles, then `iddr_rdata`=0xDEADBEEF with stall low.
- Read 0x100 again, then read 0x102 (same word). Required: no `mem_req`, stall stays 0, data 0xDEADBEEF.
- Write 0x100 with 0x12345678 and ack after 1 cycle. Required: one `mem_req` with `mem_we`=1 and `mem_addr`=0x100. Then a read of 0x100 hits with 0x12345678.
- Hold write 0x200 asserted for 5 cycles after WR_DONE. Required: exactly one `mem_req` pulse train.
- Assert read and write together at 0x300. Required: write issued (`mem_we`=1), read ignored.
- Assert `rst_n` low during RD_WAIT, then send a late `mem_ack`. Required: `mem_req`=0 at once, `buf_valid`=0, late ack ignored, next read of 0x100 misses.
